exu_acc: RTL

- Execute/sequencer stage directly downstream of the instruction fetch/decode stage.
- Consumes the decoded 4-bit control_bus and the DATA_LEN immediate, and runs them on an accumulator, a 4-entry register file and Z/C flags.
- Owns the program counter and drives the fetch request back to the fetch/decode stage, closing the fetch -> decode -> execute loop.

---
 rtl/exu_acc.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/exu_acc.sv
// Execute/sequencer stage: runs decoded ops on an accumulator, 4-entry regfile and Z/C flags,
// and owns the pc that drives fetch requests back to fetch/decode.
module exu_acc #(
   parameter int INST_CAP = 20,
   parameter int DATA_LEN = 8,
   parameter int WAIT_MAX = 7
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start,
   input  logic                        dec_valid,
   input  logic [3:0]                  control_bus,
   input  logic [DATA_LEN-1:0]         data,
   output logic                        fetch_en,
   output logic [$clog2(INST_CAP):0]   pc,
   output logic [DATA_LEN-1:0]         acc,
   output logic                        zf,
   output logic                        cf,
   output logic [DATA_LEN-1:0]         out_port,
   output logic                        out_valid,
   output logic                        halted,
   output logic                        err
);
   localparam int PCW = $clog2(INST_CAP) + 1;
   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam logic [PCW-1:0] LAST_PC   = PCW'(INST_CAP - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT} state_e;

   localparam logic [3:0] OP_LDI  = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3, OP_ANDI = 4'h4,
                          OP_ORI  = 4'h5, OP_XORI = 4'h6, OP_SHL  = 4'h7, OP_SHR  = 4'h8,
                          OP_JMP  = 4'h9, OP_JZ   = 4'hA, OP_JC   = 4'hB, OP_LDR  = 4'hC,
                          OP_STR  = 4'hD, OP_OUT  = 4'hE, OP_HLT  = 4'hF;

   state_e              state_q, state_d;
   logic [PCW-1:0]      pc_q, pc_d;
   logic [DATA_LEN-1:0] acc_q, acc_d;
   logic [DATA_LEN-1:0] regs_q [4];
   logic [DATA_LEN-1:0] regs_d [4];
   logic                zf_q, zf_d, cf_q, cf_d;
   logic [DATA_LEN-1:0] out_port_q, out_port_d;
   logic                out_valid_q, out_valid_d;
   logic                err_q, err_d;
   logic [WCW-1:0]      wcnt_q, wcnt_d;
   logic [3:0]          op_q, op_d;
   logic [DATA_LEN-1:0] imm_q, imm_d;

   logic [DATA_LEN:0]   sum, diff;
   logic [PCW-1:0]      tgt, pc_inc;
   logic                take;

   assign sum    = {1'b0, acc_q} + {1'b0, imm_q};
   assign diff   = {1'b0, acc_q} - {1'b0, imm_q};
   assign tgt    = PCW'(imm_q);
   assign pc_inc = (pc_q == LAST_PC) ? '0 : pc_q + PCW'(1);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      regs_d      = regs_q;
      zf_d        = zf_q;
      cf_d        = cf_q;
      out_port_d  = out_port_q;
      out_valid_d = 1'b0;
      err_d       = err_q;
      wcnt_d      = wcnt_q;
      op_d        = op_q;
      imm_d       = imm_q;
      take        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dec_valid) begin
               op_d    = control_bus;
               imm_d   = data;
               wcnt_d  = '0;
               state_d = S_EXEC;
            end else if (wcnt_q == WAIT_LAST) begin
               // decode never answered: re-request the same pc
               wcnt_d  = '0;
               state_d = S_FETCH;
            end else begin
               wcnt_d  = wcnt_q + WCW'(1);
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            case (op_q)
               OP_LDI:  acc_d = imm_q;
               OP_ADDI: {cf_d, acc_d} = sum;
               OP_SUBI: {cf_d, acc_d} = diff;
               OP_ANDI: begin acc_d = acc_q & imm_q; cf_d = 1'b0; end
               OP_ORI:  begin acc_d = acc_q | imm_q; cf_d = 1'b0; end
               OP_XORI: begin acc_d = acc_q ^ imm_q; cf_d = 1'b0; end
               OP_SHL:  begin acc_d = {acc_q[DATA_LEN-2:0], 1'b0}; cf_d = acc_q[DATA_LEN-1]; end
               OP_SHR:  begin acc_d = {1'b0, acc_q[DATA_LEN-1:1]}; cf_d = acc_q[0]; end
               OP_JMP:  take = 1'b1;
               OP_JZ:   take = zf_q;
               OP_JC:   take = cf_q;
               OP_LDR:  acc_d = regs_q[imm_q[1:0]];
               OP_STR:  regs_d[imm_q[1:0]] = acc_q;
               OP_OUT:  begin out_port_d = acc_q; out_valid_d = 1'b1; end
               OP_HLT:  state_d = S_HALT;
               default: ;
            endcase
            if ((op_q >= OP_LDI && op_q <= OP_SHR) || op_q == OP_LDR)
               zf_d = (acc_d == '0);
            if (take) begin
               if (tgt > LAST_PC) begin
                  err_d   = 1'b1;
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end else begin
                  pc_d    = tgt;
               end
            end
         end
         S_HALT: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         acc_q       <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
         zf_q        <= 1'b0;
         cf_q        <= 1'b0;
         out_port_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         wcnt_q      <= '0;
         op_q        <= '0;
         imm_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         regs_q      <= regs_d;
         zf_q        <= zf_d;
         cf_q        <= cf_d;
         out_port_q  <= out_port_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         wcnt_q      <= wcnt_d;
         op_q        <= op_d;
         imm_q       <= imm_d;
      end
   end

   assign fetch_en  = (state_q == S_FETCH);
   assign halted    = (state_q == S_HALT);
   assign pc        = pc_q;
   assign acc       = acc_q;
   assign zf        = zf_q;
   assign cf        = cf_q;
   assign out_port  = out_port_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule
